cross_bar_rr_arbiter: RTL and testbench

Per-slave round-robin arbiter for the cross bar: one instance per slave port picks one master among those addressing that slave, and holds the one-hot grant until the slave acknowledges the transaction. A watchdog releases a grant whose slave never answers. Its grant vector drives the crossbar's master→slave mux and the OR-reduced grant matrix used for ack/rdata return.

---
 rtl/cross_bar_pkg.sv | 19 +
 rtl/cross_bar_rr_pick.sv | 40 ++++
 rtl/cross_bar_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_cross_bar_rr_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cross_bar_pkg.sv
// Shared constants and types for the cross bar arbitration logic.
package cross_bar_pkg;

    localparam int MASTER_N     = 4;
    localparam int ARB_TIMEOUT  = 256;
    localparam int MASTER_IDX_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;

    typedef logic [MASTER_N-1:0]     msgrant_t;
    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

    // Watchdog counter width; a disabled watchdog (0) still needs one bit.
    function automatic int wd_width(input int timeout_cycles);
        if (timeout_cycles < 1) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/cross_bar_rr_pick.sv
// Combinational rotating-priority picker: finds the first request at or
// above the pointer, wrapping around, via a double-width priority encode.
module cross_bar_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick_oh,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl_req;
    logic           found;

    // Lower half holds requests at/above the pointer, upper half the full
    // vector, so the lowest set bit overall is the rotating-priority winner.
    always_comb begin
        mask     = '0;
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl_req = {req, req & mask};
        for (int i = 0; i < 2*N; i++) begin
            if (!found && dbl_req[i]) begin
                found             = 1'b1;
                pick_oh[i % N]    = 1'b1;
                pick_idx          = IW'(i % N);
            end
        end
    end

    assign pick_any = |req;

endmodule

// File: rtl/cross_bar_rr_arbiter.sv
// Per-slave round-robin arbiter: holds a one-hot grant until the slave acks,
// the granted master withdraws, or the watchdog gives up on the slave.
module cross_bar_rr_arbiter #(
    parameter int MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int TIMEOUT  = cross_bar_pkg::ARB_TIMEOUT
) (
    input  logic                                          clk,
    input  logic                                          areset,
    input  logic [MASTER_N-1:0]                           master_req,
    input  logic                                          slave_ack,
    output logic [MASTER_N-1:0]                           grant,
    output logic [((MASTER_N > 1) ? $clog2(MASTER_N) : 1)-1:0] grant_idx,
    output logic                                          busy,
    output logic                                          timeout
);

    import cross_bar_pkg::*;

    localparam int IW   = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
    localparam int WD_W = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          state_q,     state_d;
    logic [MASTER_N-1:0] grant_q,     grant_d;
    logic [IW-1:0]       grant_idx_q, grant_idx_d;
    logic                busy_q,      busy_d;
    logic                timeout_q,   timeout_d;
    logic [IW-1:0]       ptr_q,       ptr_d;
    logic [WD_W-1:0]     wd_q,        wd_d;

    logic [MASTER_N-1:0] pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic [IW-1:0]       ptr_next;
    logic                granted_req;

    cross_bar_rr_pick #(
        .N  (MASTER_N),
        .IW (IW)
    ) u_pick (
        .req      (master_req),
        .ptr      (ptr_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    assign ptr_next    = (grant_idx_q == IW'(MASTER_N - 1)) ? '0 : grant_idx_q + 1'b1;
    assign granted_req = |(master_req & grant_q);

    // Next-state logic: ack beats a withdrawn request, which beats the watchdog.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d     = ST_BUSY;
                    grant_d     = pick_oh;
                    grant_idx_d = pick_idx;
                    busy_d      = 1'b1;
                    wd_d        = '0;
                end
            end
            ST_BUSY: begin
                if (slave_ack || !granted_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end else if ((TIMEOUT != 0) && (wd_q == WD_MAX)) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = ptr_next;
                    timeout_d = 1'b1;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All outputs are registered; reset returns everything to idle.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cross_bar_rr_arbiter.sv
// Directed testbench for cross_bar_rr_arbiter with MASTER_N=4, TIMEOUT=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cross_bar_rr_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       areset;
    logic [3:0] master_req;
    logic       slave_ack;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    cross_bar_rr_arbiter #(
        .MASTER_N (N),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .master_req (master_req),
        .slave_ack  (slave_ack),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .timeout    (timeout)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Checks grant/busy/timeout, and grant_idx only while a grant is held.
    task automatic checkState(input string tag, input logic [3:0] expGrant, input logic [1:0] expIdx,
                              input logic expBusy, input logic expTimeout);
        checkOutput({tag, "_grant"},   32'(grant),   32'(expGrant));
        checkOutput({tag, "_busy"},    32'(busy),    32'(expBusy));
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'(expTimeout));
        if (expBusy) begin
            checkOutput({tag, "_idx"}, 32'(grant_idx), 32'(expIdx));
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic ack);
        master_req = req;
        slave_ack  = ack;
    endtask

    // Pulses ack for one cycle, checks the idle bubble, then sets the next request.
    task automatic ackAndIdle(input string tag, input logic [3:0] reqDuring, input logic [3:0] reqAfter);
        applyStimulus(reqDuring, 1'b1);
        @(negedge clk);
        checkState(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(reqAfter, 1'b0);
    endtask

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL sim_watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset values.
        areset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkState("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("reset_idx", 32'(grant_idx), 32'd0);
        areset = 1'b0;

        // Ack while idle must not start anything.
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkState("idle_ack", 4'b0000, 2'd0, 1'b0, 1'b0);

        // All four masters requesting: grants 0,1,2,3,0 with one idle bubble each.
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkState($sformatf("rr%0d", k), 4'(1 << order[k]), 2'(order[k]), 1'b1, 1'b0);
            @(negedge clk);
            @(negedge clk);
            checkState($sformatf("rr%0d_hold", k), 4'(1 << order[k]), 2'(order[k]), 1'b1, 1'b0);
            ackAndIdle($sformatf("rr%0d_bubble", k), 4'b1111, (k == 4) ? 4'b0000 : 4'b1111);
        end

        // Pointer is 1: grant master 1, leaving the pointer at 2.
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        checkState("p1", 4'b0010, 2'd1, 1'b1, 1'b0);
        ackAndIdle("p1_ack", 4'b0010, 4'b0011);

        // Pointer 2 with req 0011 wraps past 2,3 to master 0, then master 1.
        @(negedge clk);
        checkState("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
        ackAndIdle("wrap0_ack", 4'b0011, 4'b0011);
        @(negedge clk);
        checkState("wrap1", 4'b0010, 2'd1, 1'b1, 1'b0);
        ackAndIdle("wrap1_ack", 4'b0010, 4'b0000);

        // Watchdog: master 3 never acked, grant held cycles 1..8, pulse at 9.
        applyStimulus(4'b1000, 1'b0);
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clk);
            checkState($sformatf("tmo_c%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkState("tmo_fire", 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b1001, 1'b0);
        @(negedge clk);
        checkState("tmo_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        ackAndIdle("tmo_ptr0_ack", 4'b1001, 4'b0000);

        // Ack arriving in the same cycle the watchdog would expire: no pulse.
        applyStimulus(4'b0010, 1'b0);
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clk);
            checkState($sformatf("race_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        applyStimulus(4'b0010, 1'b1);
        @(negedge clk);
        checkState("race_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0);

        // Granted master withdraws without ack; pointer moves on to 3.
        applyStimulus(4'b0110, 1'b0);
        @(negedge clk);
        checkState("drop_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        checkState("drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0110, 1'b0);
        @(negedge clk);
        checkState("drop_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        ackAndIdle("drop_next_ack", 4'b0110, 4'b0000);

        // Asynchronous reset in the middle of a grant to master 2.
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        checkState("arst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        areset = 1'b1;
        #1;
        checkState("arst_now", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("arst_now_idx", 32'(grant_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkState("arst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
        areset = 1'b0;
        @(negedge clk);
        checkState("arst_after", 4'b0100, 2'd2, 1'b1, 1'b0);
        ackAndIdle("arst_after_ack", 4'b0100, 4'b0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
